// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run controller: FSM states, host command opcodes,
// halt causes and the default halt instruction word.
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_RUN  = 2'b01,
    OP_STEP = 2'b10,
    OP_HALT = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_HOST = 2'b01,
    CAUSE_BP   = 2'b10,
    CAUSE_INST = 2'b11
  } halt_cause_t;

  localparam logic [31:0] DEFAULT_HALT_INST = 32'h0000_0073;

endpackage

`default_nettype wire

// File: rtl/ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the retired-cycle count.
`default_nettype none

module ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// Host-side run controller: loads imem over a word stream, then sequences the core
// through run / single-step / halt with breakpoint and halt-instruction detection.
`default_nettype none

module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          CYC_W     = 32,
  parameter logic [31:0] HALT_INST = DEFAULT_HALT_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  output logic              cmd_ready,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       cpu_pc,
  input  logic [31:0]       cpu_inst,
  output logic              cpu_start,
  output logic              cpu_ce,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [2:0]        state_o,
  output logic [1:0]        halt_cause,
  output logic [CYC_W-1:0]  cycle_cnt
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wptr, wptr_nx;
  halt_cause_t       cause, cause_nx;
  logic              resume_mask, resume_mask_nx;
  logic              cnt_clr;
  logic              inst_hit, bp_hit;
  cmd_op_t           op;

  assign op       = cmd_op_t'(cmd_op);
  assign inst_hit = (cpu_inst == HALT_INST);
  // Breakpoint is suppressed for one cycle after resuming so RUN can step past it.
  assign bp_hit   = bp_en && (cpu_pc == bp_addr) && !resume_mask;

  assign imem_addr  = wptr;
  assign imem_wdata = ld_ready ? ld_data : 32'h0;
  assign state_o    = state;
  assign halt_cause = cause;

  always_comb begin
    state_nx       = state;
    wptr_nx        = wptr;
    cause_nx       = cause;
    resume_mask_nx = 1'b0;
    cnt_clr        = 1'b0;
    cpu_ce         = 1'b0;
    cmd_ready      = 1'b0;
    ld_ready       = 1'b0;
    imem_we        = 1'b0;

    case (state)
      ST_IDLE, ST_HALTED: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (op)
            OP_LOAD: begin
              state_nx = ST_LOAD;
              wptr_nx  = '0;
              cause_nx = CAUSE_NONE;
              cnt_clr  = 1'b1;
            end
            OP_RUN: begin
              state_nx       = ST_RUN;
              resume_mask_nx = (state == ST_HALTED);
              cnt_clr        = (state == ST_IDLE);
            end
            OP_STEP: begin
              state_nx = ST_STEP;
              cnt_clr  = (state == ST_IDLE);
            end
            default: ;
          endcase
        end
      end

      ST_LOAD: begin
        ld_ready = 1'b1;
        imem_we  = ld_valid;
        if (ld_valid) begin
          wptr_nx = wptr + ADDR_W'(1);
          // Stop at the top of imem rather than wrapping onto word 0.
          if (ld_last || (wptr == '1)) state_nx = ST_IDLE;
        end
      end

      ST_RUN: begin
        cmd_ready = 1'b1;
        if (inst_hit) begin
          cause_nx = CAUSE_INST;
          state_nx = ST_HALTED;
        end else if (bp_hit) begin
          cause_nx = CAUSE_BP;
          state_nx = ST_HALTED;
        end else begin
          cpu_ce = 1'b1;
          if (cmd_valid && (op == OP_HALT)) begin
            cause_nx = CAUSE_HOST;
            state_nx = ST_HALTED;
          end
        end
      end

      ST_STEP: begin
        state_nx = ST_HALTED;
        if (inst_hit) begin
          cause_nx = CAUSE_INST;
        end else begin
          cpu_ce   = 1'b1;
          cause_nx = CAUSE_HOST;
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wptr        <= '0;
      cause       <= CAUSE_NONE;
      resume_mask <= 1'b0;
      cpu_start   <= 1'b0;
    end else begin
      state       <= state_nx;
      wptr        <= wptr_nx;
      cause       <= cause_nx;
      resume_mask <= resume_mask_nx;
      cpu_start   <= (state_nx == ST_RUN) || (state_nx == ST_STEP) || (state_nx == ST_HALTED);
    end
  end

  ctrl_sat_counter #(
    .W (CYC_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cpu_ce),
    .count (cycle_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// Randomized + directed bench for cpu_run_ctrl with a simple core model driving cpu_pc/cpu_inst
// and a behavioural controller model compared every cycle.
`default_nettype none

module tb_cpu_run_ctrl;

  localparam int          ADDR_W  = 8;
  localparam int          CYC_W   = 6;
  localparam logic [31:0] HALT    = 32'h0000_0073;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam longint      CNT_MAX = (64'd1 << CYC_W) - 1;
  localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_STEP = 3, S_HALTED = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'b00;
  logic              cmd_ready;
  logic              ld_valid = 1'b0;
  logic [31:0]       ld_data = 32'h0;
  logic              ld_last = 1'b0;
  logic              ld_ready;
  logic              bp_en = 1'b0;
  logic [31:0]       bp_addr = 32'h0;
  logic [31:0]       cpu_pc;
  wire  [31:0]       cpu_inst;
  logic              cpu_start, cpu_ce, imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [2:0]        state_o;
  logic [1:0]        halt_cause;
  logic [CYC_W-1:0]  cycle_cnt;

  int checks = 0;
  int errors = 0;

  cpu_run_ctrl #(.ADDR_W(ADDR_W), .CYC_W(CYC_W), .HALT_INST(HALT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .bp_en(bp_en), .bp_addr(bp_addr), .cpu_pc(cpu_pc), .cpu_inst(cpu_inst),
    .cpu_start(cpu_start), .cpu_ce(cpu_ce), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .state_o(state_o), .halt_cause(halt_cause), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // Minimal core: PC held at 0 while start is low, advances one word per enabled cycle.
  logic [31:0] mem [0:255];
  always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;
  always @(posedge clk or posedge rst) begin
    if (rst)             cpu_pc <= 32'h0;
    else if (!cpu_start) cpu_pc <= 32'h0;
    else if (cpu_ce)     cpu_pc <= cpu_pc + 32'd4;
  end
  assign cpu_inst = mem[cpu_pc[9:2]];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference of the controller.
  int     m_state = S_IDLE, m_wptr = 0, m_cause = 0;
  longint m_cnt = 0;
  bit     m_mask = 1'b0;
  int     ce_count = 0;

  task automatic model_cycle();
    bit e_rdy, e_ldr, e_we, e_start, e_ce, ihit, bhit, acc;
    if (rst) begin
      m_state = S_IDLE; m_wptr = 0; m_cause = 0; m_cnt = 0; m_mask = 1'b0;
    end
    e_rdy   = (m_state == S_IDLE) || (m_state == S_HALTED) || (m_state == S_RUN);
    e_ldr   = (m_state == S_LOAD);
    e_we    = e_ldr && ld_valid;
    e_start = (m_state == S_RUN) || (m_state == S_STEP) || (m_state == S_HALTED);
    ihit    = (cpu_inst == HALT);
    bhit    = bp_en && (cpu_pc == bp_addr) && !m_mask;
    e_ce    = ((m_state == S_RUN) && !ihit && !bhit) || ((m_state == S_STEP) && !ihit);

    chk("state", state_o, m_state);
    chk("cmd_ready", cmd_ready, e_rdy);
    chk("ld_ready", ld_ready, e_ldr);
    chk("imem_we", imem_we, e_we);
    if (e_we) begin
      chk("imem_addr", imem_addr, m_wptr);
      chk("imem_wdata", imem_wdata, ld_data);
    end
    chk("cpu_start", cpu_start, e_start);
    chk("cpu_ce", cpu_ce, e_ce);
    chk("halt_cause", halt_cause, m_cause);
    chk("cycle_cnt", cycle_cnt, m_cnt);
    if (cpu_ce) ce_count++;

    if (!rst) begin
      acc = cmd_valid && e_rdy;
      if (e_ce && m_cnt < CNT_MAX) m_cnt++;
      case (m_state)
        S_IDLE, S_HALTED: if (acc) begin
          if (cmd_op == 2'd0) begin
            m_state = S_LOAD; m_wptr = 0; m_cnt = 0; m_cause = 0;
          end else if (cmd_op == 2'd1) begin
            if (m_state == S_IDLE) m_cnt = 0;
            m_mask  = (m_state == S_HALTED);
            m_state = S_RUN;
          end else if (cmd_op == 2'd2) begin
            if (m_state == S_IDLE) m_cnt = 0;
            m_state = S_STEP;
          end
        end
        S_LOAD: if (ld_valid) begin
          if (ld_last || m_wptr == 255) m_state = S_IDLE;
          m_wptr++;
        end
        S_RUN: begin
          if (!e_ce) begin
            m_cause = ihit ? 3 : 2; m_state = S_HALTED;
          end else if (acc && cmd_op == 2'd3) begin
            m_cause = 1; m_state = S_HALTED;
          end
          m_mask = 1'b0;
        end
        S_STEP: begin
          m_cause = ihit ? 3 : 1; m_state = S_HALTED;
        end
        default: m_state = S_IDLE;
      endcase
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_cycle();
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    cmd_valid = 1'b1; cmd_op = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (state_o != 3'(s) && n < budget) begin tick(); n++; end
    chk("wait_state", state_o, s);
  endtask

  task automatic load_prog(input int n, input int halt_idx);
    send_cmd(2'd0);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1; ld_data = (i == halt_idx) ? HALT : NOP; ld_last = (i == n - 1);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_cpu_start"}, cpu_start, 0);
    chk({tag, "_cpu_ce"}, cpu_ce, 0);
    chk({tag, "_cause"}, halt_cause, 0);
    chk({tag, "_cnt"}, cycle_cnt, 0);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    ld_valid = 1'b0; cmd_valid = 1'b0;
    @(negedge clk); @(posedge clk); #2 rst = 1'b0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] words [0:299];
    int acc_beats, ce_base;

    repeat (2) tick();
    chk("reset_state", state_o, 0);
    chk("reset_cnt", cycle_cnt, 0);
    #1 rst = 1'b0;
    tick();

    // Four-word load ending on ld_last.
    send_cmd(2'd0);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = 32'hA500_0000 + 32'(i); ld_last = (i == 3);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("load4_idle", state_o, S_IDLE);
    for (int i = 0; i < 4; i++) chk("load4_mem", mem[i], 32'hA500_0000 + 32'(i));

    // Run to a halt instruction at word 5.
    load_prog(6, 5);
    ce_base = ce_count;
    send_cmd(2'd1);
    wait_state(S_HALTED, 50);
    chk("run_cause", halt_cause, 3);
    chk("run_cnt", cycle_cnt, 5);
    chk("run_ce_cycles", ce_count - ce_base, 5);

    // Breakpoint, then three single steps, then run into the halt instruction.
    load_prog(6, 5);
    bp_en = 1'b1; bp_addr = 32'h8;
    send_cmd(2'd1);
    wait_state(S_HALTED, 50);
    chk("bp_cause", halt_cause, 2);
    chk("bp_pc", cpu_pc, 32'h8);
    chk("bp_cnt", cycle_cnt, 2);
    for (int i = 0; i < 3; i++) begin
      send_cmd(2'd2);
      tick();
      chk("step_state", state_o, S_HALTED);
      chk("step_cause", halt_cause, 1);
    end
    chk("step_pc", cpu_pc, 32'h14);
    chk("step_cnt", cycle_cnt, 5);
    send_cmd(2'd1);
    wait_state(S_HALTED, 10);
    chk("step_run_cause", halt_cause, 3);

    // Resume past the breakpoint.
    load_prog(6, 5);
    send_cmd(2'd1);
    wait_state(S_HALTED, 50);
    chk("bp2_cause", halt_cause, 2);
    send_cmd(2'd1);
    wait_state(S_HALTED, 50);
    chk("resume_cause", halt_cause, 3);
    chk("resume_pc", cpu_pc, 32'h14);
    chk("resume_cnt", cycle_cnt, 5);
    bp_en = 1'b0;

    // Host halt: the cycle carrying the HALT command still executes.
    load_prog(40, 39);
    send_cmd(2'd1);
    repeat (3) tick();
    send_cmd(2'd3);
    chk("host_state", state_o, S_HALTED);
    chk("host_cause", halt_cause, 1);
    chk("host_cnt", cycle_cnt, 4);
    chk("host_pc", cpu_pc, 32'h10);
    send_cmd(2'd3);
    chk("halt_in_halted", state_o, S_HALTED);

    // Over-long load stops at the top of imem.
    send_cmd(2'd0);
    acc_beats = 0;
    for (int i = 0; i < 300; i++) begin
      words[i] = $urandom;
      if (words[i] == HALT) words[i] = NOP;
      ld_valid = 1'b1; ld_data = words[i]; ld_last = 1'b0;
      @(negedge clk);
      if (ld_ready) acc_beats++;
      tick();
    end
    ld_valid = 1'b0;
    chk("load300_beats", acc_beats, 256);
    chk("load300_state", state_o, S_IDLE);
    chk("load300_ld_ready", ld_ready, 0);
    chk("load300_mem0", mem[0], words[0]);
    chk("load300_mem255", mem[255], words[255]);

    // Long run saturates the cycle counter.
    send_cmd(2'd1);
    repeat (80) tick();
    send_cmd(2'd3);
    chk("sat_cnt", cycle_cnt, CNT_MAX);
    chk("sat_cause", halt_cause, 1);

    // Asynchronous reset mid-LOAD and mid-RUN.
    send_cmd(2'd0);
    ld_valid = 1'b1; ld_data = 32'h1234_5678;
    async_reset_check("rst_load");
    load_prog(40, 39);
    send_cmd(2'd1);
    repeat (3) tick();
    async_reset_check("rst_run");

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      ld_valid  = ($urandom_range(0, 3) != 0);
      ld_data   = ($urandom_range(0, 7) == 0) ? HALT : (NOP | (32'($urandom_range(0, 255)) << 12));
      ld_last   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) begin
        bp_en   = $urandom_range(0, 1) == 1;
        bp_addr = 32'($urandom_range(0, 15)) << 2;
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; cmd_valid = 1'b0; ld_valid = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
